// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: the response-owner
// encoding and the default parameter values used by the top and the
// starve counter.
// Ports: none (package).
package dmem_arb_pkg;

  // Who receives the completion pulse in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam logic [7:0] IO_BASE_DEFAULT  = 8'hF8;
  localparam int         MAX_WAIT_DEFAULT = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the two requester ports (CPU, DMA) and the data-memory port.
// Ports:
//   cpu_*  : CPU request (req/we/addr/wdata), grant and completion (rvalid/rdata)
//   dma_*  : DMA request, grant, completion and protection error
//   addr/data/mw : data-memory address, write data, write enable
//   q      : data-memory read data, one cycle after addr is sampled
// Modports: slave = arbiter view, master = requesters + memory view.
interface dmem_arbiter_if;

  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt;
  logic       cpu_rvalid;
  logic [7:0] cpu_rdata;

  logic       dma_req;
  logic       dma_we;
  logic [7:0] dma_addr;
  logic [7:0] dma_wdata;
  logic       dma_gnt;
  logic       dma_rvalid;
  logic [7:0] dma_rdata;
  logic       dma_err;

  logic [7:0] addr;
  logic [7:0] data;
  logic       mw;
  logic [7:0] q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata, dma_err,
    output addr, data, mw,
    input  q
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
    input  addr, data, mw,
    output q
  );

endinterface

// File: rtl/dmem_starve_ctr.sv
// dmem_starve_ctr
// Counts consecutive cycles in which the DMA requester is denied, saturating
// at MAX_WAIT. Any grant or any cycle without a request restarts the count.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   req       : DMA request
//   gnt       : DMA grant this cycle
//   at_limit  : count has reached MAX_WAIT, DMA must win the next contest
module dmem_starve_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic gnt,
  output logic at_limit
);

  localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

  logic [3:0] count;
  logic [3:0] count_next;

  always_comb begin
    count_next = count;
    if (!req || gnt) begin
      count_next = '0;
    end else if (count != LIMIT) begin
      count_next = count + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign at_limit = (count == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-requester arbiter in front of a single-port data memory. CPU has
// priority unless the DMA has been starved for MAX_WAIT cycles. Grants are
// combinational; one access per cycle, completion one cycle later. DMA writes
// into the IO window [IO_BASE..8'hFF] are accepted but suppressed and flagged.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : dmem_arbiter_if.slave (requesters and memory port)
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter logic [7:0] IO_BASE  = IO_BASE_DEFAULT,
  parameter int         MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  logic   at_limit;
  logic   dma_wins;
  logic   cpu_gnt_c;
  logic   dma_gnt_c;
  logic   dma_io_write;

  owner_t owner_q, owner_d;
  logic   we_q, we_d;
  logic   err_q, err_d;

  // Grant decision; reset gates grants off immediately so no access starts
  // while the response register is being cleared.
  always_comb begin
    dma_wins     = bus.dma_req && (!bus.cpu_req || at_limit);
    cpu_gnt_c    = !rst && bus.cpu_req && !dma_wins;
    dma_gnt_c    = !rst && dma_wins;
    dma_io_write = bus.dma_we && (bus.dma_addr >= IO_BASE);
  end

  dmem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.dma_req),
    .gnt      (dma_gnt_c),
    .at_limit (at_limit)
  );

  // Memory port mux and response-register next state.
  always_comb begin
    bus.cpu_gnt = cpu_gnt_c;
    bus.dma_gnt = dma_gnt_c;
    bus.addr    = '0;
    bus.data    = '0;
    bus.mw      = 1'b0;
    owner_d     = OWN_NONE;
    we_d        = 1'b0;
    err_d       = 1'b0;
    if (cpu_gnt_c) begin
      bus.addr = bus.cpu_addr;
      bus.data = bus.cpu_wdata;
      bus.mw   = bus.cpu_we;
      owner_d  = OWN_CPU;
      we_d     = bus.cpu_we;
    end else if (dma_gnt_c) begin
      bus.addr = bus.dma_addr;
      bus.data = bus.dma_wdata;
      bus.mw   = bus.dma_we && !dma_io_write;
      owner_d  = OWN_DMA;
      we_d     = bus.dma_we;
      err_d    = dma_io_write;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // Completion side: only reads return memory data, and only to the owner.
  always_comb begin
    bus.cpu_rvalid = !rst && (owner_q == OWN_CPU);
    bus.dma_rvalid = !rst && (owner_q == OWN_DMA);
    bus.cpu_rdata  = (bus.cpu_rvalid && !we_q) ? bus.q : 8'h00;
    bus.dma_rdata  = (bus.dma_rvalid && !we_q) ? bus.q : 8'h00;
    bus.dma_err    = bus.dma_rvalid && err_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a behavioural 256x8 synchronous
// memory. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// Ports: none (top-level bench).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [7:0] mem [256];

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memory: write on mw, read data registered from addr.
  always @(posedge clk) begin
    if (bus.mw) begin
      mem[bus.addr] <= bus.data;
    end
    bus.q <= mem[bus.addr];
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_inputs(input logic cr, input logic cw, input logic [7:0] ca,
                            input logic [7:0] cd, input logic dr, input logic dw,
                            input logic [7:0] da, input logic [7:0] dd);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.dma_req   = dr;
    bus.dma_we    = dw;
    bus.dma_addr  = da;
    bus.dma_wdata = dd;
  endtask

  // One cycle: drive after the rising edge, return at the falling edge.
  task automatic apply_stimulus(input logic cr, input logic cw, input logic [7:0] ca,
                                input logic [7:0] cd, input logic dr, input logic dw,
                                input logic [7:0] da, input logic [7:0] dd);
    @(posedge clk);
    #1;
    set_inputs(cr, cw, ca, cd, dr, dw, da, dd);
    @(negedge clk);
  endtask

  task automatic apply_idle();
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic apply_both();
    apply_stimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'hFA] = 8'h77;
    bus.q = 8'h00;

    // Reset with a live CPU request: grant and memory port must stay quiet.
    rst = 1'b1;
    set_inputs(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check_output("rst_cpu_gnt", bus.cpu_gnt, 0);
    check_output("rst_dma_gnt", bus.dma_gnt, 0);
    check_output("rst_addr", bus.addr, 0);
    check_output("rst_mw", bus.mw, 0);
    check_output("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    check_output("rst_dma_rvalid", bus.dma_rvalid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_inputs(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

    // Lone CPU read of 8'h10.
    apply_stimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    check_output("cpu_gnt_rd", bus.cpu_gnt, 1);
    check_output("dma_gnt_rd", bus.dma_gnt, 0);
    check_output("addr_rd", bus.addr, 8'h10);
    check_output("mw_rd", bus.mw, 0);
    apply_idle();
    check_output("cpu_rvalid_rd", bus.cpu_rvalid, 1);
    check_output("cpu_rdata_rd", bus.cpu_rdata, 8'h5A);
    check_output("dma_rvalid_rd", bus.dma_rvalid, 0);
    check_output("cpu_gnt_idle", bus.cpu_gnt, 0);
    check_output("addr_idle", bus.addr, 0);
    apply_idle();
    check_output("cpu_rvalid_once", bus.cpu_rvalid, 0);

    // DMA write into the IO window, then just below it, back to back.
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFA, 8'h33);
    check_output("dma_gnt_io", bus.dma_gnt, 1);
    check_output("cpu_gnt_io", bus.cpu_gnt, 0);
    check_output("addr_io", bus.addr, 8'hFA);
    check_output("mw_io", bus.mw, 0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hF7, 8'h44);
    check_output("dma_rvalid_io", bus.dma_rvalid, 1);
    check_output("dma_err_io", bus.dma_err, 1);
    check_output("dma_rdata_io", bus.dma_rdata, 0);
    check_output("dma_gnt_f7", bus.dma_gnt, 1);
    check_output("mw_f7", bus.mw, 1);
    check_output("data_f7", bus.data, 8'h44);
    apply_idle();
    check_output("dma_rvalid_f7", bus.dma_rvalid, 1);
    check_output("dma_err_f7", bus.dma_err, 0);
    check_output("mem_fa", mem[8'hFA], 8'h77);
    check_output("mem_f7", mem[8'hF7], 8'h44);

    // CPU write then DMA read of the same address, then DMA read of IO.
    apply_stimulus(1'b1, 1'b1, 8'h20, 8'hA1, 1'b0, 1'b0, 8'h00, 8'h00);
    check_output("cpu_gnt_wr", bus.cpu_gnt, 1);
    check_output("mw_wr", bus.mw, 1);
    check_output("data_wr", bus.data, 8'hA1);
    check_output("dma_err_quiet", bus.dma_err, 0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00);
    check_output("cpu_rvalid_wr", bus.cpu_rvalid, 1);
    check_output("cpu_rdata_wr", bus.cpu_rdata, 0);
    check_output("dma_gnt_rd20", bus.dma_gnt, 1);
    check_output("mw_rd20", bus.mw, 0);
    apply_stimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFA, 8'h00);
    check_output("dma_rvalid_rd20", bus.dma_rvalid, 1);
    check_output("dma_rdata_rd20", bus.dma_rdata, 8'hA1);
    check_output("cpu_rvalid_rd20", bus.cpu_rvalid, 0);
    check_output("cpu_rdata_rd20", bus.cpu_rdata, 0);
    check_output("dma_gnt_iord", bus.dma_gnt, 1);
    apply_idle();
    check_output("dma_rvalid_iord", bus.dma_rvalid, 1);
    check_output("dma_err_iord", bus.dma_err, 0);
    check_output("dma_rdata_iord", bus.dma_rdata, 8'h77);

    // Continuous contention: four CPU grants then one forced DMA grant.
    for (int i = 0; i < 10; i++) begin
      apply_both();
      check_output("rr_cpu_gnt", bus.cpu_gnt, (i % 5) != 4);
      check_output("rr_dma_gnt", bus.dma_gnt, (i % 5) == 4);
      check_output("rr_one_grant", bus.cpu_gnt & bus.dma_gnt, 0);
    end

    // Dropping dma_req restarts the starve count.
    apply_idle();
    for (int i = 0; i < 3; i++) begin
      apply_both();
      check_output("starve_pre", bus.dma_gnt, 0);
    end
    apply_stimulus(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    check_output("starve_drop", bus.cpu_gnt, 1);
    for (int i = 0; i < 4; i++) begin
      apply_both();
      check_output("starve_post", bus.dma_gnt, 0);
    end
    apply_both();
    check_output("starve_forced_dma", bus.dma_gnt, 1);
    check_output("starve_forced_cpu", bus.cpu_gnt, 0);

    // Reset in the middle of a CPU read grant, with starve count built up.
    apply_idle();
    for (int i = 0; i < 3; i++) begin
      apply_both();
      check_output("rst_pre_build", bus.cpu_gnt, 1);
    end
    apply_stimulus(1'b1, 1'b0, 8'h10, 8'hC3, 1'b1, 1'b0, 8'h20, 8'h00);
    check_output("rst_pre_gnt", bus.cpu_gnt, 1);
    check_output("rst_pre_data", bus.data, 8'hC3);
    check_output("rst_pre_rvalid", bus.cpu_rvalid, 1);
    #1;
    rst = 1'b1;
    #1;
    check_output("rst_now_cpu_gnt", bus.cpu_gnt, 0);
    check_output("rst_now_dma_gnt", bus.dma_gnt, 0);
    check_output("rst_now_addr", bus.addr, 0);
    check_output("rst_now_data", bus.data, 0);
    check_output("rst_now_cpu_rvalid", bus.cpu_rvalid, 0);
    check_output("rst_now_cpu_rdata", bus.cpu_rdata, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_inputs(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    check_output("rst_no_rvalid", bus.cpu_rvalid, 0);
    check_output("rst_no_rdata", bus.cpu_rdata, 0);
    for (int i = 0; i < 5; i++) begin
      apply_both();
      check_output("post_rst_cpu_gnt", bus.cpu_gnt, i < 4);
      check_output("post_rst_dma_gnt", bus.dma_gnt, i == 4);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter IO_BASE, default 8'hF8, lowest address of the memory-mapped IO window (IO_BASE..8'hFF).
REQ-002 Parameter MAX_WAIT, default 4, cycles the DMA requester may be denied before forced grant; legal range 1..15.
REQ-003 CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 cpu_req / cpu_we  in  1 / 1  CPU access request; write when cpu_we=1.
REQ-006 cpu_addr / cpu_wdata  in  8 / 8  CPU address and write data.
REQ-007 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-008 cpu_rvalid / cpu_rdata  out  1 / 8  CPU completion pulse and read data.
REQ-009 dma_req / dma_we  in  1 / 1  DMA access request; write when dma_we=1.
REQ-010 dma_addr / dma_wdata  in  8 / 8  DMA address and write data.
REQ-011 dma_gnt  out  1  DMA request accepted this cycle.
REQ-012 dma_rvalid / dma_rdata / dma_err  out  1 / 8 / 1  DMA completion pulse, read data, protection error.
REQ-013 ADDR / DATA / MW  out  8 / 8 / 1  data-memory address, write data, write enable.
REQ-014 Q  in  8  data-memory read data, valid one cycle after ADDR is sampled.

Function
REQ-015 At most one of cpu_gnt, dma_gnt SHALL be high in any cycle; grants are combinational from req inputs and registered arbitration state.
REQ-016 Default priority: CPU wins when both request, unless starve count equals MAX_WAIT, then DMA wins.
REQ-017 Starve count: +1 per cycle with dma_req=1 and dma_gnt=0, saturating at MAX_WAIT; cleared to 0 on dma_gnt or dma_req=0.
REQ-018 Lone requester SHALL be granted in the same cycle it requests.
REQ-019 In a granted cycle ADDR, DATA SHALL equal the winner's addr/wdata and MW SHALL equal winner's we; with no grant ADDR=0, DATA=0, MW=0.
REQ-020 DMA write with dma_addr >= IO_BASE SHALL be granted but drive MW=0 and return dma_err=1 with dma_rvalid; DMA reads of the IO window are permitted.
REQ-021 CPU accesses are never protection-checked.
REQ-022 Response register captures owner, we and err at each grant; next cycle the owner's rvalid pulses exactly once.
REQ-023 On a read response, rdata SHALL equal Q; on a write response rdata SHALL be 0; the non-owner's rdata SHALL be 0.
REQ-024 dma_err SHALL be high only together with dma_rvalid.
REQ-025 Back-to-back grants SHALL be sustained: one access per cycle, grant in N, response in N+1, overlapping grant N+1.
REQ-026 Requester SHALL hold req and fields stable until gnt is sampled; the arbiter keeps no per-request buffering.

Reset
REQ-027 RESET high SHALL immediately force cpu_gnt, dma_gnt, MW, ADDR, DATA, all rvalid, rdata and dma_err to 0 and clear starve count and response register.
REQ-028 A grant occurring in the cycle RESET asserts SHALL produce no response after RESET deasserts.
REQ-029 After RESET deasserts the first grant follows REQ-016 with starve count 0.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold the owner enumeration (OWN_NONE, OWN_CPU, OWN_DMA) and the default IO_BASE and MAX_WAIT constants.
REQ-031 Starve counter SHALL be a sub-module dmem_starve_ctr (inputs req, gnt; output at_limit); the rest is flat.

Verification
REQ-032 CPU read only, addr 8'h10, memory holds 8'h5A -> cpu_gnt cycle N, ADDR=8'h10, MW=0; cpu_rvalid and cpu_rdata=8'h5A in N+1.
REQ-033 cpu_req and dma_req held high continuously, MAX_WAIT=4 -> four CPU grants, then one DMA grant, pattern repeats; never two grants in a cycle.
REQ-034 DMA write addr 8'hFA data 8'h33 -> dma_gnt, MW=0, next cycle dma_rvalid=1, dma_err=1; memory at 8'hFA unchanged; DMA write 8'hF7 -> MW=1, dma_err=0.
REQ-035 Alternating CPU write 8'h20<=8'hA1 then DMA read 8'h20 in consecutive cycles -> dma_rdata=8'hA1, rvalid pulses in consecutive cycles.
REQ-036 RESET asserted in the cycle of a CPU read grant -> all outputs 0 at once; no cpu_rvalid after deassert; starve count 0.
REQ-037 dma_req dropped after 3 denied cycles, then reasserted with CPU busy -> DMA granted only after 4 further denials.
